// File: rtl/sms_msg_rx_if.sv
// rtl/sms_msg_rx_if.sv - byte-stream and message-output bundle for sms_msg_rx
//
// Purpose: groups the modem receive byte stream and the assembled-message
//          outputs of sms_msg_rx into one interface.
// Signals:
//   rx_data  [7:0]    received ASCII byte
//   rx_valid          rx_data valid, one byte per cycle
//   start             one-cycle pulse, message/mode newly valid
//   message  [256:1]  payload [256:129], PIN ASCII [128:97], zero [96:1]
//   mode     [1:0]    decoded mode 0..3
//   busy              frame being assembled
//   err_cnt  [7:0]    rejected frame count, saturating at 255
// Modports: master drives bytes and observes results; slave is the receiver.
interface sms_msg_rx_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         start;
    logic [256:1] message;
    logic [1:0]   mode;
    logic         busy;
    logic [7:0]   err_cnt;

    modport master (
        output rx_data, rx_valid,
        input  start, message, mode, busy, err_cnt
    );

    modport slave (
        input  rx_data, rx_valid,
        output start, message, mode, busy, err_cnt
    );
endinterface

// File: rtl/sms_msg_rx.sv
// rtl/sms_msg_rx.sv - ASCII frame parser '#' PPPP M payload CR feeding sms_msg_dec
//
// Purpose: parses frames from the modem byte stream, assembles the 256-bit
//          message word and 2-bit mode, and pulses start for one cycle when a
//          complete frame has been received.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   bus    sms_msg_rx_if.slave: rx_data/rx_valid in; start, message, mode,
//          busy, err_cnt out
// Parameters:
//   MAX_PAYLOAD  maximum payload bytes after the mode character (1..16)
//   TIMEOUT_CYC  idle cycles allowed between bytes of one frame
// Optional feature: define SMS_RX_TIMEOUT_EN to build the inter-byte timeout;
//   without it a partial frame waits indefinitely.
module sms_msg_rx #(
    parameter int MAX_PAYLOAD = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic          clk,
    input logic          rst,
    sms_msg_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIN,
        ST_MODE,
        ST_DATA,
        ST_DONE
    } state_t;

    localparam logic [7:0]   C_HASH   = 8'h23;
    localparam logic [7:0]   C_CR     = 8'h0D;
    localparam logic [127:0] C_SPACES = {16{8'h20}};

    state_t       r_state;
    state_t       w_state_nxt;

    logic [31:0]  r_pin;
    logic [1:0]   r_pin_idx;
    logic [127:0] r_pay;
    logic [4:0]   r_pay_cnt;
    logic [1:0]   r_wmode;
    logic [256:1] r_message;
    logic [1:0]   r_mode;
    logic [7:0]   r_err_cnt;

    logic w_is_hash;
    logic w_is_digit;
    logic w_is_mode;
    logic w_is_cr;
    logic w_busy;
    logic w_tmo;
    logic w_restart;
    logic w_pin_wr;
    logic w_mode_wr;
    logic w_pay_wr;
    logic w_done;
    logic w_err;

    assign w_is_hash  = (bus.rx_data == C_HASH);
    assign w_is_cr    = (bus.rx_data == C_CR);
    assign w_is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign w_is_mode  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h33);
    assign w_busy     = (r_state == ST_PIN) || (r_state == ST_MODE) || (r_state == ST_DATA);

`ifdef SMS_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_idle_cnt;

    // Counts idle cycles inside a frame; any byte (accepted or rejected)
    // restarts the count, and leaving the frame clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_busy || bus.rx_valid) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive idle cycle after the last byte.
    assign w_tmo = w_busy && !bus.rx_valid && (r_idle_cnt == TW'(TIMEOUT_CYC - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign w_tmo        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_pin_wr    = 1'b0;
        w_mode_wr   = 1'b0;
        w_pay_wr    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // DONE lasts one cycle; a byte arriving then is handled as in IDLE.
                if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
                if (bus.rx_valid && w_is_hash) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_PIN;
                end
            end
            ST_PIN: begin
                if (bus.rx_valid) begin
                    if (w_is_hash) begin
                        w_restart   = 1'b1;
                        w_state_nxt = ST_PIN;
                    end else if (w_is_digit) begin
                        w_pin_wr = 1'b1;
                        if (r_pin_idx == 2'd3) begin
                            w_state_nxt = ST_MODE;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_MODE: begin
                if (bus.rx_valid) begin
                    if (w_is_hash) begin
                        w_restart   = 1'b1;
                        w_state_nxt = ST_PIN;
                    end else if (w_is_mode) begin
                        w_mode_wr   = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    if (w_is_hash) begin
                        w_restart   = 1'b1;
                        w_state_nxt = ST_PIN;
                    end else if (w_is_cr) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (r_pay_cnt < 5'(MAX_PAYLOAD)) begin
                        w_pay_wr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_tmo) begin
            w_err = 1'b1;
        end
        if (w_err) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pin     <= '0;
            r_pin_idx <= '0;
            r_pay     <= '0;
            r_pay_cnt <= '0;
            r_wmode   <= '0;
            r_message <= '0;
            r_mode    <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_restart) begin
                r_pin     <= '0;
                r_pin_idx <= '0;
                r_pay     <= C_SPACES;
                r_pay_cnt <= '0;
                r_wmode   <= '0;
            end

            if (w_pin_wr) begin
                case (r_pin_idx)
                    2'd0:    r_pin[31:24] <= bus.rx_data;
                    2'd1:    r_pin[23:16] <= bus.rx_data;
                    2'd2:    r_pin[15:8]  <= bus.rx_data;
                    default: r_pin[7:0]   <= bus.rx_data;
                endcase
                r_pin_idx <= r_pin_idx + 2'd1;
            end

            if (w_mode_wr) begin
                r_wmode <= bus.rx_data[1:0];
            end

            // Payload byte k occupies r_pay[127-8k -: 8], i.e. message[256-8k -: 8].
            if (w_pay_wr) begin
                for (int i = 0; i < 16; i++) begin
                    if (r_pay_cnt == 5'(i)) begin
                        r_pay[127-8*i -: 8] <= bus.rx_data;
                    end
                end
                r_pay_cnt <= r_pay_cnt + 5'd1;
            end

            // Outputs are loaded on the CR edge so they are stable during DONE.
            if (w_done) begin
                r_message <= {r_pay, r_pin, 96'b0};
                r_mode    <= r_wmode;
            end

            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.start   = (r_state == ST_DONE);
    assign bus.busy    = w_busy;
    assign bus.message = r_message;
    assign bus.mode    = r_mode;
    assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sms_msg_rx.sv
// tb/tb_sms_msg_rx.sv - self-checking bench for sms_msg_rx
module tb_sms_msg_rx;
    localparam int MAXP = 16;
    localparam int TMO  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sms_msg_rx_if bus ();

    sms_msg_rx #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: keeps the bytes received since the last '#', and judges
    // each new byte by its position in the frame.
    bit           m_active;
    byte unsigned m_cur[$];
    logic [256:1] m_msg;
    logic [1:0]   m_mode;
    int           m_err;
    bit           m_start;
    int           m_idle;

    function automatic void model_reset();
        m_active = 0;
        m_cur.delete();
        m_msg   = '0;
        m_mode  = '0;
        m_err   = 0;
        m_start = 0;
        m_idle  = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b);
        bit err;
        int n;
        int np;
        err     = 0;
        m_start = 0;
        if (v) begin
            m_idle = 0;
            if (b == 8'h23) begin
                m_active = 1;
                m_cur.delete();
            end else if (m_active) begin
                m_cur.push_back(b);
                n = m_cur.size();
                if (n <= 4) begin
                    err = !(b >= 8'h30 && b <= 8'h39);
                end else if (n == 5) begin
                    err = !(b >= 8'h30 && b <= 8'h33);
                end else if (b == 8'h0D) begin
                    np    = n - 6;
                    m_msg = '0;
                    for (int k = 0; k < 16; k++)
                        m_msg[256-8*k -: 8] = (k < np) ? m_cur[5+k] : 8'h20;
                    for (int i = 0; i < 4; i++)
                        m_msg[128-8*i -: 8] = m_cur[i];
                    m_mode   = 2'(m_cur[4] - 8'h30);
                    m_start  = 1;
                    m_active = 0;
                end else begin
                    err = (n - 5 > MAXP);
                end
            end
        end else if (m_active) begin
`ifdef SMS_RX_TIMEOUT_EN
            m_idle++;
            if (m_idle >= TMO) err = 1;
`endif
        end
        if (err) begin
            m_active = 0;
            if (m_err < 255) m_err++;
        end
    endfunction

    task automatic step(input bit v, input logic [7:0] b);
        bus.rx_valid = v;
        bus.rx_data  = v ? b : 8'h00;
        @(posedge clk);
        model_step(v, b);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic send_cr();
        step(1'b1, 8'h0D);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", bus.start); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", bus.err_cnt); end
        total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", bus.mode); end
        total++; if (bus.message !== 256'd0) begin bad++; $display("FAIL reset_msg got=%h exp=0", bus.message); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        send_str("#12342ON");
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL basic_early_start got=%b exp=0", bus.start); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
        send_cr();
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL basic_start got=%b exp=1", bus.start); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_done_busy got=%b exp=0", bus.busy); end
        total++; if (bus.message[128:97] !== 32'h31323334) begin bad++; $display("FAIL basic_pin got=%h exp=31323334", bus.message[128:97]); end
        total++; if (bus.mode !== 2'd2) begin bad++; $display("FAIL basic_mode got=%0d exp=2", bus.mode); end
        total++; if (bus.message[256:241] !== 16'h4F4E) begin bad++; $display("FAIL basic_payload got=%h exp=4f4e", bus.message[256:241]); end
        total++; if (bus.message[240:129] !== {14{8'h20}}) begin bad++; $display("FAIL basic_spaces got=%h exp=%h", bus.message[240:129], {14{8'h20}}); end
        total++; if (bus.message[96:1] !== 96'd0) begin bad++; $display("FAIL basic_zero got=%h exp=0", bus.message[96:1]); end
        idle(1);
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL basic_pulse_len got=%b exp=0", bus.start); end
    endtask

    task automatic test_full_payload();
        send_str("#43210");
        repeat (16) step(1'b1, 8'h41);
        send_cr();
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL full_start got=%b exp=1", bus.start); end
        total++; if (bus.message[256:129] !== {16{8'h41}}) begin bad++; $display("FAIL full_payload got=%h exp=%h", bus.message[256:129], {16{8'h41}}); end
        total++; if (bus.message !== m_msg) begin bad++; $display("FAIL full_msg got=%h exp=%h", bus.message, m_msg); end
        total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL full_mode got=%0d exp=0", bus.mode); end
        idle(1);
    endtask

    task automatic test_overflow();
        logic [256:1] prev;
        prev = m_msg;
        send_str("#43210");
        repeat (17) step(1'b1, 8'h41);
        total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL ovf_err got=%0d exp=1", bus.err_cnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ovf_busy got=%b exp=0", bus.busy); end
        send_cr();
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL ovf_start got=%b exp=0", bus.start); end
        total++; if (bus.message !== prev) begin bad++; $display("FAIL ovf_msg got=%h exp=%h", bus.message, prev); end
        idle(1);
    endtask

    task automatic test_bad_chars();
        send_str("#12X4");
        total++; if (bus.err_cnt !== 8'd2) begin bad++; $display("FAIL badpin_err got=%0d exp=2", bus.err_cnt); end
        send_str("#12349");
        total++; if (bus.err_cnt !== 8'd3) begin bad++; $display("FAIL badmode_err got=%0d exp=3", bus.err_cnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL badmode_busy got=%b exp=0", bus.busy); end
        send_cr();
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL bad_start got=%b exp=0", bus.start); end
        idle(1);
    endtask

    task automatic test_restart_and_reset();
        send_str("#12#56781");
        send_cr();
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL rst_start got=%b exp=1", bus.start); end
        total++; if (bus.message[128:97] !== 32'h35363738) begin bad++; $display("FAIL rst_pin got=%h exp=35363738", bus.message[128:97]); end
        total++; if (bus.mode !== 2'd1) begin bad++; $display("FAIL rst_mode got=%0d exp=1", bus.mode); end
        total++; if (bus.err_cnt !== 8'd3) begin bad++; $display("FAIL rst_noerr got=%0d exp=3", bus.err_cnt); end
        idle(1);
        send_str("#12");
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy got=%b exp=1", bus.busy); end
        do_reset();
        total++; if ({bus.start, bus.busy, bus.mode, bus.err_cnt} !== 12'd0) begin bad++; $display("FAIL midrst_outs got=%h exp=0", {bus.start, bus.busy, bus.mode, bus.err_cnt}); end
        total++; if (bus.message !== 256'd0) begin bad++; $display("FAIL midrst_msg got=%h exp=0", bus.message); end
        send_str("#11110");
        send_cr();
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL postrst_start got=%b exp=1", bus.start); end
        total++; if (bus.message !== m_msg) begin bad++; $display("FAIL postrst_msg got=%h exp=%h", bus.message, m_msg); end
        idle(1);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = m_err;
        send_str("#12");
        idle(TMO - 1);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL tmo_busy_before got=%b exp=1", bus.busy); end
        idle(1);
`ifdef SMS_RX_TIMEOUT_EN
        total++; if (bus.err_cnt !== 8'(e0 + 1)) begin bad++; $display("FAIL tmo_err got=%0d exp=%0d", bus.err_cnt, e0 + 1); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b exp=0", bus.busy); end
        send_str("34");
        send_cr();
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL tmo_start got=%b exp=0", bus.start); end
`else
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL notmo_busy got=%b exp=1", bus.busy); end
        send_str("340");
        send_cr();
        total++; if (bus.start !== 1'b1) begin bad++; $display("FAIL notmo_start got=%b exp=1", bus.start); end
        total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL notmo_mode got=%0d exp=0", bus.mode); end
        total++; if (bus.err_cnt !== 8'(e0)) begin bad++; $display("FAIL notmo_err got=%0d exp=%0d", bus.err_cnt, e0); end
`endif
        idle(1);
    endtask

    function automatic byte unsigned rnd_payload_byte();
        byte unsigned c;
        c = 8'($urandom_range(8'h21, 8'h7E));
        if (c == 8'h23) c = 8'h2A;
        return c;
    endfunction

    task automatic test_random();
        byte unsigned q[$];
        int r;
        int np;
        for (int f = 0; f < 150; f++) begin
            q.delete();
            r = $urandom_range(0, 9);
            if (r <= 5 || r == 8) begin
                q.push_back(8'h23);
                for (int i = 0; i < 4; i++) q.push_back(8'($urandom_range(8'h30, 8'h39)));
                q.push_back(8'($urandom_range(8'h30, 8'h33)));
                np = (r == 5) ? MAXP + 1 : $urandom_range(0, MAXP);
                for (int i = 0; i < np; i++) q.push_back(rnd_payload_byte());
                q.push_back(8'h0D);
                if (r == 8) q[$urandom_range(1, q.size() - 1)] = rnd_payload_byte();
            end else if (r <= 7) begin
                q.push_back(8'h23);
                for (int i = 0; i < 6; i++) begin
                    case ($urandom_range(0, 4))
                        0: q.push_back(8'h23);
                        1: q.push_back(8'h0D);
                        2: q.push_back(8'h41);
                        default: q.push_back(8'($urandom_range(8'h30, 8'h39)));
                    endcase
                end
            end
            for (int i = 0; i <= q.size(); i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    idle(TMO + 5);
                end else if ($urandom_range(0, 3) == 0) begin
                    idle($urandom_range(1, 3));
                end
                if (i < q.size()) step(1'b1, q[i]);
                else step(1'b0, 8'h00);
                total++; if (bus.start !== m_start) begin bad++; $display("FAIL rnd_start f=%0d got=%b exp=%b", f, bus.start, m_start); end
                total++; if (bus.busy !== m_active) begin bad++; $display("FAIL rnd_busy f=%0d got=%b exp=%b", f, bus.busy, m_active); end
                total++; if (bus.err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rnd_err f=%0d got=%0d exp=%0d", f, bus.err_cnt, m_err); end
                total++; if (bus.mode !== m_mode) begin bad++; $display("FAIL rnd_mode f=%0d got=%0d exp=%0d", f, bus.mode, m_mode); end
                total++; if (bus.message !== m_msg) begin bad++; $display("FAIL rnd_msg f=%0d got=%h exp=%h", f, bus.message, m_msg); end
            end
        end
    endtask

    task automatic test_saturate();
        repeat (260) send_str("#X");
        total++; if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_err got=%0d exp=255", bus.err_cnt); end
        total++; if (bus.err_cnt !== 8'(m_err)) begin bad++; $display("FAIL sat_model got=%0d exp=%0d", bus.err_cnt, m_err); end
        send_str("#X");
        total++; if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", bus.err_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_payload();
        test_overflow();
        test_bad_chars();
        test_restart_and_reset();
        test_timeout();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sms_msg_rx.md
Name: sms_msg_rx

Overview:
- Upstream framing stage for sms_msg_dec.
- Consumes the ASCII byte stream from the GSM modem receive path and parses frames of the form '#' PPPP M payload CR.
- Assembles the 256-bit message word and the 2-bit mode, then pulses start for one cycle so sms_msg_dec can act on a complete, stable message.

Parameters:
- MAX_PAYLOAD, 16, maximum payload bytes after the mode character (1..16).
- TIMEOUT_CYC, 1000000, idle clock cycles allowed between bytes of one frame before the frame is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous to clk, active-high.
- rx_data  input  8  received ASCII byte.
- rx_valid  input  1  rx_data valid; one byte per cycle in which it is high.
- start  output  1  one-cycle pulse: message and mode are newly valid.
- message  output  256  bits [256:129] hold the payload, bits [128:97] hold the PIN ASCII, bits [96:1] are zero.
- mode  output  2  decoded mode, 0..3.
- busy  output  1  high while a frame is being assembled.
- err_cnt  output  8  count of rejected frames, saturating at 255.

Behaviour:
- Reset values: start=0, message=0, mode=0, busy=0, err_cnt=0, FSM in IDLE, all internal buffers cleared.
- States: IDLE, PIN, MODE, DATA, DONE.
- IDLE:
  - Ignores every byte except 0x23 '#'.
  - On '#': clear the working buffer, go to PIN, assert busy.
- PIN:
  - Accepts 4 bytes, each 0x30..0x39.
  - The first PIN byte lands in working[128:121] and the fourth in working[104:97].
  - Any other byte is an error.
  - After the fourth byte, go to MODE.
- MODE:
  - Accepts one byte 0x30..0x33; the working mode is the byte minus 0x30.
  - Any other byte is an error.
  - On a valid byte, go to DATA.
- DATA:
  - Byte 0x0D ends the frame and moves to DONE.
  - Any other byte is stored at payload index k, k=0 at [256:249], with k incrementing.
  - Unfilled payload bytes are 0x20 (space).
  - When the payload already holds MAX_PAYLOAD bytes, one more non-CR byte is an error.
  - An empty payload ('#', PIN, mode, CR) is legal.
- DONE (one cycle):
  - Copy working to message and working mode to mode.
  - start=1 for exactly this cycle, busy=0, return to IDLE.
  - message and mode hold until the next DONE; they are never changed by error frames.
- Latency: start goes high on the clock edge after the cycle in which the CR is accepted, i.e. 1 cycle after the CR.
- '#' received in PIN, MODE or DATA:
  - Restarts the frame: buffer cleared, state PIN.
  - Not counted as an error.
- Error:
  - err_cnt increments by 1, saturating at 255.
  - Go to IDLE with busy=0.
  - The offending byte is consumed; a faulty '#' is impossible, since '#' always restarts the frame.
- Timeout:
  - A counter runs while busy and resets on every accepted byte.
  - Reaching TIMEOUT_CYC is an error, with the same handling as above.
- rx_valid in DONE: the byte is treated as if in IDLE; DONE is never stalled.
- rst mid-frame: immediate return to the reset values; the partial frame is discarded and no start is issued.

Optional Feature:
- Macro: SMS_RX_TIMEOUT_EN.
- Defined: inter-byte timeout as described, with the counter width set by TIMEOUT_CYC.
- Undefined: no timeout logic is synthesised; a frame waits indefinitely in PIN/MODE/DATA until it completes, hits an error, receives '#', or sees rst.

Test Plan:
- Basic frame: send "#12342ON" CR.
  - Expected: one start pulse 1 cycle after the CR.
  - Expected: message[128:97]=32'h31323334, mode=2, message[256:241]=16'h4F4E, message[240:129] all 0x20, message[96:1]=0.
- Full payload: send "#43210" + 16 x 'A' + CR.
  - Expected: start, and message[256:129] all 0x41.
- Payload overflow: send 17 x 'A' instead.
  - Expected: no start, err_cnt=1, busy=0, message unchanged from the previous frame.
- Bad characters: send "#12X4" and "#12349".
  - Expected: err_cnt increments twice, no start.
- Restart and mid-frame reset: send "#12" then "#56781" CR.
  - Expected: start with PIN 0x35363738 and mode=1.
  - Then send "#12" followed by rst for one cycle.
  - Expected: all outputs return to 0, and a following "#11110" CR still produces start.
- Timeout (SMS_RX_TIMEOUT_EN defined, TIMEOUT_CYC=20): send "#12", then idle for 20 cycles.
  - Expected: err_cnt=1 and busy=0 at cycle 20.
  - Then send "34" CR. Expected: no start.
  - With the macro undefined, the same stimulus followed by "340" CR.
  - Expected: start with mode=0.
